// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding encodings,
// controller states and a saturating increment helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [1:0] {
    S_RUN,
    S_LU_STALL,
    S_MEM_WAIT,
    S_FLUSH
  } state_e;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one ALU operand; the MEM-stage result beats
// the WB-stage result, and x0 is never forwarded.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              reg_write_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              reg_write_wb,
  output logic [1:0]        fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_mem && (rd_mem != '0) && (rd_mem == rs)) begin
      fwd = FWD_MEM;
    end else if (reg_write_wb && (rd_wb != '0) && (rd_wb == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: freeze on a busy
// data memory, flush on taken branches, one-cycle load-use stall, plus counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned BRANCH_STAGE = 3,
  parameter int unsigned MAX_WAIT     = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              uses_rs1_id,
  input  logic              uses_rs2_id,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              mem_read_ex,
  input  logic [REG_AW-1:0] rs1_ex,
  input  logic [REG_AW-1:0] rs2_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              reg_write_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              reg_write_wb,
  input  logic              branch_taken,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              memwb_bubble,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [1:0]        fwd_a_raw, fwd_b_raw;
  logic              lu;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs            (rs1_ex),
    .rd_mem        (rd_mem),
    .reg_write_mem (reg_write_mem),
    .rd_wb         (rd_wb),
    .reg_write_wb  (reg_write_wb),
    .fwd           (fwd_a_raw)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs            (rs2_ex),
    .rd_mem        (rd_mem),
    .reg_write_mem (reg_write_mem),
    .rd_wb         (rd_wb),
    .reg_write_wb  (reg_write_wb),
    .fwd           (fwd_b_raw)
  );

  assign forward_a = reset ? FWD_RF : fwd_a_raw;
  assign forward_b = reset ? FWD_RF : fwd_b_raw;

  assign lu = mem_read_ex && (rd_ex != '0) &&
              ((uses_rs1_id && (rs1_id == rd_ex)) || (uses_rs2_id && (rs2_id == rd_ex)));

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    state_d      = S_RUN;
    if (!reset) begin
      if (dmem_busy) begin
        // Freeze wins over a branch; the branch stays held and re-asserts later.
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
        state_d      = S_MEM_WAIT;
      end else if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = (BRANCH_STAGE == 3);
        state_d     = S_FLUSH;
      end else if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_d     = S_LU_STALL;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      wait_q       <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state_q <= state_d;
      if (dmem_busy) begin
        if (wait_q != WAIT_W'(MAX_WAIT)) wait_q <= wait_q + 1'b1;
        if (wait_q >= WAIT_W'(MAX_WAIT - 1)) mem_timeout <= 1'b1;
      end else begin
        wait_q <= '0;
      end
      if (state_d == S_MEM_WAIT || state_d == S_LU_STALL) begin
        stall_cycles <= CNT_W'(sat_inc(64'(stall_cycles), CNT_W));
      end
      if (state_d == S_FLUSH) begin
        flush_events <= CNT_W'(sat_inc(64'(flush_events), CNT_W));
      end
    end
  end

  // A load-use stall lasts exactly one cycle; a repeat means the stimulus is wrong.
  lu_stall_once: assert property (@(posedge clk) disable iff (reset)
    !(state_q == S_LU_STALL && lu));

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline.
- Generates PC/IF-ID write enables, ID/EX bubble, per-stage flushes, full-pipeline freeze, and forwarding selects for both ALU operands.
- Adds behaviour the current stall/forwarding pair lacks:
  - load-use detection from the EX stage,
  - branch flush for a configurable resolution stage,
  - multi-cycle data-memory freeze with timeout,
  - saturating performance counters.
- Sits beside the stage registers; all stage registers consume its enables.

Parameters:
REG_AW, 5, register address width
BRANCH_STAGE, 3, stage that drives branch_taken: 2=EX, 3=MEM
MAX_WAIT, 16, dmem_busy cycles before mem_timeout is set
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rs1_id  in  REG_AW  ID-stage source 1
rs2_id  in  REG_AW  ID-stage source 2
uses_rs1_id  in  1  ID instruction reads rs1
uses_rs2_id  in  1  ID instruction reads rs2
rd_ex  in  REG_AW  EX-stage destination
mem_read_ex  in  1  EX instruction is a load
rs1_ex  in  REG_AW  EX-stage source 1
rs2_ex  in  REG_AW  EX-stage source 2
rd_mem  in  REG_AW  MEM-stage destination
reg_write_mem  in  1  MEM writes a register
rd_wb  in  REG_AW  WB-stage destination
reg_write_wb  in  1  WB writes a register
branch_taken  in  1  taken branch resolved in BRANCH_STAGE
dmem_busy  in  1  data memory not ready this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
idex_write  out  1  ID/EX load enable
exmem_write  out  1  EX/MEM load enable
idex_bubble  out  1  zero ID/EX control fields
ifid_flush  out  1  clear IF/ID to NOP
idex_flush  out  1  clear ID/EX controls
exmem_flush  out  1  clear EX/MEM controls
memwb_bubble  out  1  insert bubble into MEM/WB
forward_a  out  2  operand A select
forward_b  out  2  operand B select
mem_timeout  out  1  sticky error flag
stall_cycles  out  CNT_W  saturating count of stall/freeze cycles
flush_events  out  CNT_W  saturating count of branch flushes

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Control outputs are combinational from inputs. state, counters, wait counter and mem_timeout are registered.
- Reset values:
  - state = S_RUN, wait counter = 0, mem_timeout = 0, stall_cycles = 0, flush_events = 0.
  - While reset is high, all write enables = 1, all flush/bubble = 0, forward_a = forward_b = 2'b00.
- Forwarding, per operand (rs = rs1_ex for A, rs2_ex for B):
  - 2'b10 if reg_write_mem, rd_mem != 0 and rd_mem == rs.
  - Otherwise 2'b01 if reg_write_wb, rd_wb != 0 and rd_wb == rs.
  - Otherwise 2'b00.
  - MEM has priority over WB. x0 is never forwarded.
- Load-use hazard (lu):
  - lu = mem_read_ex && rd_ex != 0 && ((uses_rs1_id && rs1_id == rd_ex) || (uses_rs2_id && rs2_id == rd_ex)).
- Priority, highest first:
  1. dmem_busy → freeze:
     - pc_write, ifid_write, idex_write and exmem_write = 0.
     - memwb_bubble = 1.
     - No flushes, even if branch_taken (the branch stays held and re-asserts).
  2. branch_taken → flush:
     - pc_write = 1, ifid_flush = 1, idex_flush = 1.
     - exmem_flush = 1 only if BRANCH_STAGE = 3.
     - lu is ignored (the dependent instruction is flushed).
  3. lu → stall:
     - pc_write = 0, ifid_write = 0, idex_bubble = 1.
     - Exactly one cycle; next cycle the load is in MEM and forwarding supplies 2'b10.
  4. Otherwise run: all enables = 1, all flush/bubble = 0.
- FSM (registered action of the previous cycle): S_RUN, S_LU_STALL, S_MEM_WAIT, S_FLUSH. Next state = the action chosen this cycle.
  - Being in S_LU_STALL with lu still true indicates a bench error; flag it with an assertion.
- Wait counter:
  - Increments while dmem_busy; clears when dmem_busy = 0.
  - When it reaches MAX_WAIT, mem_timeout is set and stays set until reset. Freeze continues.
- Counters:
  - stall_cycles += 1 each cycle with freeze or lu.
  - flush_events += 1 each cycle with a flush.
  - Both saturate at all-ones with no wrap.
- Reset mid-freeze or mid-stall: FSM, wait counter and counters return to reset values on the next edge.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01,
  - the state enum {S_RUN, S_LU_STALL, S_MEM_WAIT, S_FLUSH},
  - a sat_inc function.
- One sub-module, fwd_select (combinational, one per operand), instantiated twice.

Test Plan:
- Forwarding: rs1_ex = 5, rd_mem = 5, reg_write_mem = 1, rd_wb = 5, reg_write_wb = 1 → forward_a = 2'b10. Then rd_mem = 0 → 2'b01. Then rs1_ex = 0 → 2'b00.
- Load-use: mem_read_ex = 1, rd_ex = 7, rs2_id = 7, uses_rs2_id = 1 → one cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1; stall_cycles goes 0 → 1; next cycle forward_b = 2'b10.
- Branch with BRANCH_STAGE = 2 vs 3, branch_taken pulse coinciding with lu → ifid_flush = idex_flush = 1, exmem_flush = 0 (stage 2) / 1 (stage 3), no stall, flush_events = 1.
- dmem_busy held 3 cycles with branch_taken = 1 → 3 freeze cycles with no flush, then flush on cycle 4; stall_cycles = 3.
- dmem_busy held 16 cycles (MAX_WAIT = 16) → mem_timeout rises on that edge and stays 1 after busy drops; reset → 0.
- Counter saturation, CNT_W = 4: 20 lu cycles → stall_cycles = 15, no wrap.
